// File: rtl/if_stage_pkg.sv
// Shared constants, IF/ID payload type and sequential-PC helper for the fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ROM_AW  = 31;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h8000_0000;
    localparam logic [XLEN-1:0] IRQ_VECTOR_DEF = 32'h8000_0004;
    localparam logic [XLEN-1:0] NOP            = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            irq;
    } ifid_t;

    // Supervisor bit rides along untouched; only the low 31 bits advance and wrap.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1], pc[ROM_AW-1:0] + ROM_AW'(4)};
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter: priority next-PC mux (redirect, interrupt, stall, sequential).
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_irq_take,
    output logic [31:0] o_pc,
    output logic [31:0] o_seq_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_pc_next;

    assign w_seq_pc = seq_pc(r_pc);

    // A redirect may clear the supervisor bit but can never set it.
    always_comb begin
        w_pc_next = w_seq_pc;
        if (i_redirect) begin
            w_pc_next = {r_pc[XLEN-1] & i_redirect_pc[XLEN-1], i_redirect_pc[ROM_AW-1:0]};
        end else if (i_irq_take) begin
            w_pc_next = IRQ_VECTOR;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc     = r_pc;
    assign o_seq_pc = w_seq_pc;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC ownership, ROM addressing and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_irq,
    output logic [30:0] o_rom_addr,
    input  logic [31:0] i_rom_data,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc_plus4,
    output logic        o_id_valid,
    output logic        o_id_irq
);

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_seq_pc;
    logic            w_irq_take;
    ifid_t           r_ifid;
    ifid_t           w_ifid_next;

    // Interrupts are masked in supervisor mode and deferred by any competing pipeline event.
    assign w_irq_take = i_irq & ~w_pc[XLEN-1] & ~i_stall & ~i_redirect & ~i_flush;

    if_stage_pc_reg #(
        .RESET_PC   (RESET_PC),
        .IRQ_VECTOR (IRQ_VECTOR)
    ) u_pc_reg (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_irq_take    (w_irq_take),
        .o_pc          (w_pc),
        .o_seq_pc      (w_seq_pc)
    );

    assign o_rom_addr = w_pc[ROM_AW-1:0];

    // Flush leaves the PC fields alone so the bubble still carries a sensible address.
    always_comb begin
        w_ifid_next = r_ifid;
        if (i_flush) begin
            w_ifid_next.instr = NOP;
            w_ifid_next.valid = 1'b0;
            w_ifid_next.irq   = 1'b0;
        end else if (i_stall) begin
            w_ifid_next = r_ifid;
        end else if (w_irq_take) begin
            w_ifid_next.instr    = NOP;
            w_ifid_next.pc       = w_pc;
            w_ifid_next.pc_plus4 = w_seq_pc;
            w_ifid_next.valid    = 1'b0;
            w_ifid_next.irq      = 1'b1;
        end else begin
            w_ifid_next.instr    = i_rom_data;
            w_ifid_next.pc       = w_pc;
            w_ifid_next.pc_plus4 = w_seq_pc;
            w_ifid_next.valid    = 1'b1;
            w_ifid_next.irq      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ifid <= '0;
        end else begin
            r_ifid <= w_ifid_next;
        end
    end

    assign o_id_instr    = r_ifid.instr;
    assign o_id_pc       = r_ifid.pc;
    assign o_id_pc_plus4 = r_ifid.pc_plus4;
    assign o_id_valid    = r_ifid.valid;
    assign o_id_irq      = r_ifid.irq;

endmodule
